// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Multiply is shift-add into a 64-bit accumulator. Divide is restoring, with a
// 33-bit partial remainder. Operands are converted to magnitudes on accept, and
// the sign fix-up happens when the result is registered.
// Optional build macro: MULDIV_EARLY_OUT_EN. When defined, divide-by-zero,
// signed overflow and multiply-by-zero go straight from accept to DONE.
//
// Handshake: i_Start is a request that is taken only at an edge where the unit
// is idle (o_Busy=0) and i_Flush=0. The result is offered for exactly one cycle
// on o_Valid, and there is no back-pressure. o_Output holds the last result.
module muldiv_unit #(
  parameter int ITERATIONS = 32
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Start,
  input  logic [2:0]  i_Op,
  input  logic [31:0] i_Source1,
  input  logic [31:0] i_Source2,
  input  logic        i_Flush,
  output logic        o_Busy,
  output logic        o_Valid,
  output logic [31:0] o_Output,
  output logic [1:0]  o_State
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateType;

  localparam logic [4:0] LastIter = 5'(ITERATIONS - 1);

  stateType    state;
  stateType    nextState;
  logic [4:0]  iterCount;
  logic [2:0]  opReg;
  logic        sign1;
  logic        sign2;
  logic        divZero;
  logic        divOverflow;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [63:0] acc;
  logic [31:0] partRem;
  logic [31:0] resultReg;

  logic        inSigned1;
  logic        inSigned2;
  logic        inSign1;
  logic        inSign2;
  logic [31:0] inMag1;
  logic [31:0] inMag2;
  logic        inDivZero;
  logic        inOverflow;
  logic        accept;
  logic        earlyOut;
  logic        finishCalc;

  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic        quotBit;
  logic [63:0] accNext;
  logic [31:0] remNext;

  logic        negResult;
  logic [63:0] prodFix;
  logic [31:0] quotFix;
  logic [31:0] remFix;
  logic [31:0] fixResult;

  // Decode operand signedness and magnitudes from the live request.
  always_comb begin
    inSigned1  = (i_Op == 3'b001) || (i_Op == 3'b010) ||
                 (i_Op == 3'b100) || (i_Op == 3'b110);
    inSigned2  = (i_Op == 3'b001) || (i_Op == 3'b100) || (i_Op == 3'b110);
    inSign1    = inSigned1 & i_Source1[31];
    inSign2    = inSigned2 & i_Source2[31];
    inMag1     = inSign1 ? -i_Source1 : i_Source1;
    inMag2     = inSign2 ? -i_Source2 : i_Source2;
    inDivZero  = i_Op[2] && (i_Source2 == 32'd0);
    inOverflow = i_Op[2] && inSigned2 &&
                 (i_Source1 == 32'h8000_0000) && (i_Source2 == 32'hFFFF_FFFF);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [31:0] earlyResult;

  // Detect operations whose result is known at accept time.
  always_comb begin
    earlyOut    = 1'b0;
    earlyResult = 32'd0;
    if (i_Op[2]) begin
      if (inDivZero) begin
        earlyOut    = 1'b1;
        earlyResult = i_Op[1] ? i_Source1 : 32'hFFFF_FFFF;
      end else if (inOverflow) begin
        earlyOut    = 1'b1;
        earlyResult = i_Op[1] ? 32'd0 : 32'h8000_0000;
      end
    end else if ((i_Source1 == 32'd0) || (i_Source2 == 32'd0)) begin
      earlyOut    = 1'b1;
      earlyResult = 32'd0;
    end
  end
`else
  assign earlyOut = 1'b0;
`endif

  assign accept     = (state == IDLE) && i_Start && !i_Flush;
  assign finishCalc = (state == CALC) && (iterCount == LastIter) && !i_Flush;

  // One radix-2 step of the shift-add multiply or the restoring divide.
  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag1} : 33'd0);
    divShift = {partRem, acc[31]};
    quotBit  = (divShift >= {1'b0, mag2});
    remNext  = quotBit ? 32'(divShift - {1'b0, mag2}) : divShift[31:0];
    if (opReg[2]) begin
      accNext = {acc[63:32], acc[30:0], quotBit};
    end else begin
      accNext = {mulSum, acc[31:1]};
    end
  end

  // Sign fix-up and special cases, applied to the final iteration's values.
  always_comb begin
    negResult = sign1 ^ sign2;
    prodFix   = negResult ? -accNext : accNext;
    if (divZero) begin
      quotFix = 32'hFFFF_FFFF;
    end else if (divOverflow) begin
      quotFix = 32'h8000_0000;
    end else begin
      quotFix = negResult ? -accNext[31:0] : accNext[31:0];
    end
    if (divZero) begin
      remFix = sign1 ? -mag1 : mag1;
    end else if (divOverflow) begin
      remFix = 32'd0;
    end else begin
      remFix = sign1 ? -remNext : remNext;
    end
    case (opReg)
      3'b000:                 fixResult = prodFix[31:0];
      3'b001, 3'b010, 3'b011: fixResult = prodFix[63:32];
      3'b100, 3'b101:         fixResult = quotFix;
      default:                fixResult = remFix;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic; flush overrides everything.
  always_comb begin
    nextState = state;
    if (i_Flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_Start) nextState = earlyOut ? DONE : CALC;
        CALC:    if (iterCount == LastIter) nextState = DONE;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    o_Busy   = (state != IDLE);
    o_Valid  = (state == DONE);
    o_State  = state;
    o_Output = resultReg;
  end

  // Operand capture on accept, then one iteration per CALC cycle.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      iterCount   <= 5'd0;
      opReg       <= 3'd0;
      sign1       <= 1'b0;
      sign2       <= 1'b0;
      divZero     <= 1'b0;
      divOverflow <= 1'b0;
      mag1        <= 32'd0;
      mag2        <= 32'd0;
      acc         <= 64'd0;
      partRem     <= 32'd0;
    end else if (accept) begin
      iterCount   <= 5'd0;
      opReg       <= i_Op;
      sign1       <= inSign1;
      sign2       <= inSign2;
      divZero     <= inDivZero;
      divOverflow <= inOverflow;
      mag1        <= inMag1;
      mag2        <= inMag2;
      acc         <= {32'd0, (i_Op[2] ? inMag1 : inMag2)};
      partRem     <= 32'd0;
    end else if (state == CALC) begin
      iterCount   <= iterCount + 5'd1;
      acc         <= accNext;
      partRem     <= remNext;
    end
  end

  // Result register: written only on a completing edge, otherwise held.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      resultReg <= 32'd0;
    end else if (finishCalc) begin
      resultReg <= fixResult;
`ifdef MULDIV_EARLY_OUT_EN
    end else if (accept && earlyOut) begin
      resultReg <= earlyResult;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus flush, reset and back-to-back
// start sequences for muldiv_unit.
module tb_muldiv_unit;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n = 1'b1;
  logic        i_Start = 1'b0;
  logic [2:0]  i_Op = 3'd0;
  logic [31:0] i_Source1 = 32'd0;
  logic [31:0] i_Source2 = 32'd0;
  logic        i_Flush = 1'b0;
  logic        o_Busy;
  logic        o_Valid;
  logic [31:0] o_Output;
  logic [1:0]  o_State;

  muldiv_unit #(.ITERATIONS(32)) dut (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Start   (i_Start),
    .i_Op      (i_Op),
    .i_Source1 (i_Source1),
    .i_Source2 (i_Source2),
    .i_Flush   (i_Flush),
    .o_Busy    (o_Busy),
    .o_Valid   (o_Valid),
    .o_Output  (o_Output),
    .o_State   (o_State)
  );

  // Clock and watchdog
  always #5 i_Clock = ~i_Clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  localparam int LongLat = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int ShortLat = 1;
`else
  localparam int ShortLat = 33;
`endif

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
    logic        early;
  } vecType;

  vecType      vecs[26];
  logic [31:0] expQ[$];
  logic [31:0] lastOut;
  int          nCmp = 0;
  int          nErr = 0;

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: issue one op from idle, wait for o_Valid, check value and latency.
  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected, input int expLat);
    int lat;
    bit seen;
    i_Start   = 1'b1;
    i_Op      = op;
    i_Source1 = a;
    i_Source2 = b;
    @(posedge i_Clock); #1;
    i_Start   = 1'b0;
    i_Op      = 3'($urandom_range(0, 7));
    i_Source1 = $urandom;
    i_Source2 = $urandom;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (o_Valid) begin
        seen = 1'b1;
      end else begin
        @(posedge i_Clock); #1;
        lat++;
      end
    end
    check({name, "_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_result"}, o_Output, expected);
      check({name, "_latency"}, 32'(lat), 32'(expLat));
    end
    @(posedge i_Clock); #1;
    check({name, "_pulse_end"}, {31'd0, o_Valid}, 32'd0);
    check({name, "_idle_after"}, {31'd0, o_Busy}, 32'd0);
    lastOut = expected;
  endtask

  initial begin
    bit sawValid;
    logic [31:0] ca;
    logic [31:0] cb;

    vecs[0]  = '{OpMul,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{OpMulh,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{OpMul,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{OpMulh,   32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0};
    vecs[6]  = '{OpMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[7]  = '{OpMulhsu, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0};
    vecs[8]  = '{OpMul,    32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[9]  = '{OpMulhu,  32'h9ABC_DEF0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{OpDiv,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[11] = '{OpRem,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{OpDivu,   32'd100,       32'd7,         32'd14,        1'b0};
    vecs[13] = '{OpRemu,   32'd100,       32'd7,         32'd2,         1'b0};
    vecs[14] = '{OpDiv,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[15] = '{OpRem,    32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0};
    vecs[16] = '{OpDiv,    32'h7FFF_FFFF, 32'h0000_0010, 32'h07FF_FFFF, 1'b0};
    vecs[17] = '{OpRem,    32'h7FFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0};
    vecs[18] = '{OpDivu,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[19] = '{OpRem,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};
    vecs[20] = '{OpDiv,    32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[21] = '{OpRemu,   32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1'b1};
    vecs[22] = '{OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[23] = '{OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[24] = '{OpDivu,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[25] = '{OpRemu,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

    // Reset state
    i_Reset_n = 1'b0;
    repeat (2) @(posedge i_Clock);
    #1;
    check("reset_busy",   {31'd0, o_Busy},  32'd0);
    check("reset_valid",  {31'd0, o_Valid}, 32'd0);
    check("reset_output", o_Output,         32'd0);
    check("reset_state",  {30'd0, o_State}, 32'd0);
    i_Reset_n = 1'b1;
    lastOut   = 32'd0;
    @(posedge i_Clock); #1;

    // Table-driven vectors
    for (int i = 0; i < 26; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expected,
            vecs[i].early ? ShortLat : LongLat);
    end

    // Start together with flush in IDLE is not accepted
    i_Start   = 1'b1;
    i_Flush   = 1'b1;
    i_Op      = OpDivu;
    i_Source1 = 32'd50;
    i_Source2 = 32'd5;
    @(posedge i_Clock); #1;
    i_Start = 1'b0;
    i_Flush = 1'b0;
    check("flush_start_busy", {31'd0, o_Busy}, 32'd0);

    // Flush at iteration 10 of a DIV
    i_Start   = 1'b1;
    i_Op      = OpDiv;
    i_Source1 = 32'd1000;
    i_Source2 = 32'd3;
    @(posedge i_Clock); #1;
    i_Start  = 1'b0;
    sawValid = 1'b0;
    repeat (10) begin
      @(posedge i_Clock); #1;
      if (o_Valid) sawValid = 1'b1;
    end
    check("flush_iter10_state", {30'd0, o_State}, 32'd1);
    i_Flush = 1'b1;
    @(posedge i_Clock); #1;
    i_Flush = 1'b0;
    if (o_Valid) sawValid = 1'b1;
    check("flush_busy",     {31'd0, o_Busy}, 32'd0);
    check("flush_no_valid", 32'(sawValid),   32'd0);
    check("flush_output",   o_Output,        lastOut);
    runOp("after_flush", OpDivu, 32'd1000, 32'd3, 32'd333, LongLat);

    // i_Start held high with changing operands: one accept per 34 cycles
    i_Start = 1'b1;
    for (int k = 0; k < 102; k++) begin
      ca        = 32'(k * 7 + 3);
      cb        = 32'(k + 11);
      i_Op      = (((k / 34) % 2) == 0) ? OpMul : OpDivu;
      i_Source1 = ca;
      i_Source2 = cb;
      if ((k % 34) == 0) expQ.push_back((((k / 34) % 2) == 0) ? ca * cb : ca / cb);
      @(posedge i_Clock); #1;
      check("cont_valid", {31'd0, o_Valid}, {31'd0, ((k % 34) == 32)});
      if (o_Valid) begin
        if (expQ.size() == 0) begin
          check("cont_unexpected", o_Output, 32'hDEAD_0000);
        end else begin
          check("cont_result", o_Output, expQ.pop_front());
          lastOut = o_Output;
        end
      end
    end
    i_Start = 1'b0;
    check("cont_drain", 32'(expQ.size()), 32'd0);
    @(posedge i_Clock); #1;
    @(posedge i_Clock); #1;
    check("cont_idle", {31'd0, o_Busy}, 32'd0);

    // Reset asserted mid-CALC clears outputs at once
    i_Start   = 1'b1;
    i_Op      = OpMul;
    i_Source1 = 32'd9;
    i_Source2 = 32'd9;
    @(posedge i_Clock); #1;
    i_Start = 1'b0;
    repeat (5) @(posedge i_Clock);
    #2;
    i_Reset_n = 1'b0;
    #1;
    check("midreset_busy",   {31'd0, o_Busy},  32'd0);
    check("midreset_valid",  {31'd0, o_Valid}, 32'd0);
    check("midreset_output", o_Output,         32'd0);
    check("midreset_state",  {30'd0, o_State}, 32'd0);
    @(posedge i_Clock); #1;
    i_Reset_n = 1'b1;
    sawValid  = 1'b0;
    repeat (40) begin
      @(posedge i_Clock); #1;
      if (o_Valid || o_Busy) sawValid = 1'b1;
    end
    check("midreset_quiet", 32'(sawValid), 32'd0);
    runOp("after_reset", OpMul, 32'd9, 32'd9, 32'd81, LongLat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
